// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//
// UART transmitter that pulls bytes from the read port of a registered
// sync_fifo. A frame is 1 start bit, 8 data bits LSB first, an optional
// parity bit and 1 or 2 stop bits. Each byte costs exactly one read strobe.
// The FIFO's registered output is captured one cycle after that strobe.
// Bytes tagged as end-of-packet raise a one-cycle pulse once their stop
// bits have finished.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (>= 2)
//   PARITY       : 0 = none, 1 = even, 2 = odd
//   STOP_BITS    : 1 or 2
//
// Ports
//   clk            : single rising-edge clock
//   rst_n          : asynchronous active-low reset
//   tx_en          : allows a new frame to start (only looked at in IDLE)
//   fifo_empty     : FIFO empty flag
//   fifo_dout      : FIFO registered read data
//   fifo_dout_last : FIFO registered end-of-packet flag
//   fifo_rd_en     : one-cycle read strobe per byte (registered)
//   tx             : serial line, idles high (registered)
//   busy           : high in every state except IDLE (registered)
//   pkt_done       : one-cycle pulse after the stop bits of a last byte
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_dout_last,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       pkt_done
);

  localparam int                 CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]         LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             last_q;
  logic             parity_q;
  logic             bit_done;

  // The last cycle of the current bit period; every timed state advances here.
  assign bit_done = (baud_cnt == CNT_MAX);

  // Single FSM register block. Every output is a flop so the serial line and
  // the strobes never glitch. fifo_rd_en and pkt_done default low each cycle
  // so they can only ever be one-cycle pulses. bit_cnt counts data bits in
  // DATA and is reused to count stop bits in STOP; it wraps back to 0 after
  // the eighth data bit, so it is already cleared when STOP is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      last_q     <= 1'b0;
      parity_q   <= 1'b0;
      fifo_rd_en <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      pkt_done   <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      pkt_done   <= 1'b0;

      case (state)
        S_IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          // Only read when the FIFO reports data, so it can never underflow.
          if (tx_en && !fifo_empty) begin
            state      <= S_FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end

        // Read strobe is high during this cycle; the FIFO pops on the next edge.
        S_FETCH: begin
          state <= S_LOAD;
        end

        // The FIFO's registered output is now valid: capture it and start
        // driving the start bit on the same edge.
        S_LOAD: begin
          shift_reg <= fifo_dout;
          last_q    <= fifo_dout_last;
          parity_q  <= (PARITY == 2) ? ~^fifo_dout : ^fifo_dout;
          tx        <= 1'b0;
          baud_cnt  <= '0;
          state     <= S_START;
        end

        S_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            tx       <= shift_reg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // tx is loaded with the next bit on the boundary edge, which is
        // shift_reg[1] before the shift takes effect.
        S_DATA: begin
          if (bit_done) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (PARITY != 0) begin
                tx    <= parity_q;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              tx <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (bit_done) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // Stop bits are counted whole bit periods at a time; the exit edge
        // also reports end-of-packet for bytes that were tagged last.
        S_STOP: begin
          tx <= 1'b1;
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_cnt == LAST_STOP) begin
              bit_cnt  <= '0;
              busy     <= 1'b0;
              pkt_done <= last_q;
              state    <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule
